// File: rtl/fwspi_target_pkg.sv
// Shared constants for the fwspi_target SPI peripheral: register map,
// STATUS/CTRL bit positions and the byte sent when the TX holding register is empty.
package fwspi_target_pkg;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_RXF  = 0;
    localparam int ST_TXE  = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_BUSY = 3;
    localparam int ST_UNF  = 4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_RXIE = 1;
    localparam int CTRL_TXIE = 2;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    typedef enum logic {
        SHF_IDLE,
        SHF_ACTIVE
    } shf_state_t;

endpackage

// File: rtl/fwspi_target_shifter.sv
// SPI mode-0 target shifter: pin synchronizers, edge detection, bit counter
// and RX/TX shift registers. TX reloads are requested from the holding register in the top.
//
//   state      | meaning
//   SHF_IDLE   | not selected (csn high or EN=0); miso held low
//   SHF_ACTIVE | frame in progress; shifting on sck edges
module fwspi_target_shifter
    import fwspi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       sck,
    input  logic       mosi,
    input  logic       csn,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       busy,
    output logic       selected,
    output logic       miso
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] csn_q;
    logic                   sck_d;
    logic                   csn_d;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   csn_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   csn_fall;
    logic                   csn_rise;

    shf_state_t state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] rx_next;
    logic [7:0] tx_sr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sck_q  <= '0;
            mosi_q <= '0;
            csn_q  <= '1;
            sck_d  <= 1'b0;
            csn_d  <= 1'b1;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            csn_q  <= {csn_q[SYNC_STAGES-2:0], csn};
            sck_d  <= sck_s;
            csn_d  <= csn_s;
        end
    end

    assign sck_s    = sck_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign csn_s    = csn_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign csn_fall = ~csn_s & csn_d;
    assign csn_rise = csn_s & ~csn_d;

    assign rx_next = {rx_sr, mosi_s};

    // Must match exactly the cases below where tx_sr takes tx_data.
    assign tx_load = en & (((state == SHF_IDLE) & csn_fall) |
                           ((state == SHF_ACTIVE) & ~csn_rise & sck_fall & (bit_cnt == 3'd0)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= SHF_IDLE;
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            tx_sr    <= 8'd0;
            rx_valid <= 1'b0;
            rx_byte  <= 8'd0;
        end else begin
            rx_valid <= 1'b0;
            if (!en) begin
                state   <= SHF_IDLE;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    SHF_IDLE: begin
                        if (csn_fall) begin
                            state   <= SHF_ACTIVE;
                            bit_cnt <= 3'd0;
                            tx_sr   <= tx_data;
                        end
                    end
                    SHF_ACTIVE: begin
                        if (csn_rise) begin
                            state   <= SHF_IDLE;
                            bit_cnt <= 3'd0;
                        end else begin
                            if (sck_rise) begin
                                rx_sr   <= rx_next[6:0];
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    rx_valid <= 1'b1;
                                    rx_byte  <= rx_next;
                                end
                            end
                            if (sck_fall) begin
                                if (bit_cnt == 3'd0) begin
                                    tx_sr <= tx_data;
                                end else begin
                                    tx_sr <= {tx_sr[6:0], 1'b0};
                                end
                            end
                        end
                    end
                    default: state <= SHF_IDLE;
                endcase
            end
        end
    end

    assign selected = (state == SHF_ACTIVE);
    assign miso     = selected & tx_sr[7];
    assign busy     = ~csn_s;

endmodule

// File: rtl/fwspi_target.sv
// SPI mode-0 target with a Wishbone register port: RX/TX holding registers,
// sticky error flags, control bits and a level interrupt.
module fwspi_target
    import fwspi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  rt_adr,
    input  logic [31:0] rt_dat_w,
    output logic [31:0] rt_dat_r,
    input  logic        rt_cyc,
    input  logic        rt_stb,
    input  logic        rt_we,
    input  logic [3:0]  rt_sel,
    output logic        rt_ack,
    output logic        rt_err,
    output logic        inta,
    input  logic        sck,
    input  logic        mosi,
    input  logic        csn,
    output logic        miso,
    output logic        miso_oe
);

    logic       acc;
    logic [1:0] reg_sel;
    logic       rx_pop;
    logic       tx_wr;
    logic       st_wr;
    logic       ctrl_wr;
    logic [7:0] rd_mux;
    logic [7:0] rd_byte;

    logic [7:0] rxdata;
    logic [7:0] txdata;
    logic       rxf;
    logic       txf;
    logic       ovr;
    logic       unf;
    logic       en;
    logic       rxie;
    logic       txie;

    logic       tx_load;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       busy;
    logic       selected;
    logic [7:0] tx_data_sh;
    logic       unused_bits;

    fwspi_target_shifter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_shifter (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .sck      (sck),
        .mosi     (mosi),
        .csn      (csn),
        .tx_data  (tx_data_sh),
        .tx_load  (tx_load),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .busy     (busy),
        .selected (selected),
        .miso     (miso)
    );

    // Gating with rt_ack yields a single-cycle ack even if the strobe is held.
    assign acc     = rt_cyc & rt_stb & ~rt_ack;
    assign reg_sel = rt_adr[3:2];
    assign rx_pop  = acc & ~rt_we & (reg_sel == REG_RXDATA);
    assign tx_wr   = acc & rt_we & (reg_sel == REG_TXDATA);
    assign st_wr   = acc & rt_we & (reg_sel == REG_STATUS);
    assign ctrl_wr = acc & rt_we & (reg_sel == REG_CTRL);

    assign tx_data_sh = txf ? txdata : IDLE_BYTE;

    always_comb begin
        rd_mux = 8'd0;
        case (reg_sel)
            REG_RXDATA: rd_mux = rxdata;
            REG_TXDATA: rd_mux = txdata;
            REG_STATUS: begin
                rd_mux[ST_RXF]  = rxf;
                rd_mux[ST_TXE]  = ~txf;
                rd_mux[ST_OVR]  = ovr;
                rd_mux[ST_BUSY] = busy;
                rd_mux[ST_UNF]  = unf;
            end
            REG_CTRL: begin
                rd_mux[CTRL_EN]   = en;
                rd_mux[CTRL_RXIE] = rxie;
                rd_mux[CTRL_TXIE] = txie;
            end
            default: rd_mux = 8'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rt_ack  <= 1'b0;
            rd_byte <= 8'd0;
            rxdata  <= 8'd0;
            txdata  <= 8'd0;
            rxf     <= 1'b0;
            txf     <= 1'b0;
            ovr     <= 1'b0;
            unf     <= 1'b0;
            en      <= 1'b0;
            rxie    <= 1'b0;
            txie    <= 1'b0;
            inta    <= 1'b0;
        end else begin
            rt_ack <= acc;
            if (acc) begin
                rd_byte <= rt_we ? 8'd0 : rd_mux;
            end

            // A pop coinciding with a completed byte makes room for it.
            if (rx_valid && (!rxf || rx_pop)) begin
                rxdata <= rx_byte;
                rxf    <= 1'b1;
            end else if (rx_pop) begin
                rxf <= 1'b0;
            end

            if (rx_valid && rxf && !rx_pop) begin
                ovr <= 1'b1;
            end else if (st_wr && rt_dat_w[ST_OVR]) begin
                ovr <= 1'b0;
            end

            if (tx_wr) begin
                txdata <= rt_dat_w[7:0];
            end

            // The shifter has already sampled the pre-write holding state.
            if (tx_wr) begin
                txf <= 1'b1;
            end else if (tx_load) begin
                txf <= 1'b0;
            end

            if (tx_load && !txf) begin
                unf <= 1'b1;
            end else if (st_wr && rt_dat_w[ST_UNF]) begin
                unf <= 1'b0;
            end

            if (ctrl_wr) begin
                en   <= rt_dat_w[CTRL_EN];
                rxie <= rt_dat_w[CTRL_RXIE];
                txie <= rt_dat_w[CTRL_TXIE];
            end

            inta <= en & ((rxie & rxf) | (txie & ~txf));
        end
    end

    assign rt_dat_r    = {24'd0, rd_byte};
    assign rt_err      = 1'b0;
    assign miso_oe     = selected & en;
    assign unused_bits = ^{rt_sel, rt_adr[1:0], rt_dat_w[31:8]};

endmodule

// File: doc/fwspi_target.md
# fwspi_target

SPI target (slave) peripheral and the downstream partner of the team's `fwspi_initiator`: it consumes `sck`/`mosi` plus a chip-select and returns `miso`. It exposes a byte-wide RX/TX holding register pair through a Wishbone target port. It is used for initiator loopback testing and as an SoC-side SPI device. SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit frames; SPI inputs are oversampled in the `clock` domain.

## Interface
- `SYNC_STAGES`, default 2: flops in each input synchronizer (`sck`, `mosi`, `csn`); minimum 2.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rt_adr`  in  4  Wishbone address; `rt_adr[3:2]` selects the register.
- `rt_dat_w`  in  32  write data; only `[7:0]` used.
- `rt_dat_r`  out  32  read data; `[31:8]` are always 0.
- `rt_cyc`, `rt_stb`, `rt_we`  in  1 each  Wishbone cycle, strobe and write enable.
- `rt_sel`  in  4  byte selects; ignored.
- `rt_ack`  out  1  transfer acknowledge.
- `rt_err`  out  1  tied 0.
- `inta`  out  1  level interrupt.
- `sck`, `mosi`, `csn`  in  1 each  SPI pins, asynchronous to `clock`; `csn` is active-low.
- `miso`  out  1  serial data to the initiator.
- `miso_oe`  out  1  high while selected and enabled; the pad drives `miso` only when this is high.

## Operation
- Wishbone registers (address `rt_adr[3:2]`):
  - 0 RXDATA (R): `[7:0]` last received byte; a read clears RXF.
  - 1 TXDATA (R/W): `[7:0]` next byte to send; a write sets TXF (holding register full).
  - 2 STATUS:
    - `[0]` RXF (R);
    - `[1]` TXE = !TXF (R);
    - `[2]` OVR, sticky, write 1 to clear;
    - `[3]` BUSY = synchronized `csn` low (R);
    - `[4]` UNF, sticky, write 1 to clear.
  - 3 CTRL (R/W): `[0]` EN, `[1]` RXIE, `[2]` TXIE.
- Edge detection: synchronized `sck` rise/fall and `csn` fall/rise are each detected as a single-cycle pulse.
- Frame start (`csn` falls while EN=1):
  - bit counter is cleared;
  - TX shift register loads TXDATA if TXF=1 and TXF clears; otherwise it loads 8'hFF and UNF sets.
- `sck` rise while selected: shift synchronized `mosi` into the RX shift register and increment the 3-bit bit counter.
- 8th rise (counter wraps 7→0):
  - if RXF=0: the byte goes to RXDATA and RXF sets;
  - if RXF=1: the new byte is discarded, OVR sets, RXDATA is unchanged.
- `sck` fall while selected:
  - if the counter is 0 (byte boundary after the first byte), reload from TXDATA/TXF using the frame-start rule;
  - otherwise shift TX left by one.
- `miso` = TX shift `[7]` while selected, else 0. `miso_oe` = selected & EN.
- `csn` rises: return to idle. A partial RX byte is discarded; no flags change.
- EN=0:
  - SPI inputs are ignored and the shifter is forced idle;
  - clearing EN mid-frame aborts the frame the same way a `csn` rise does.
- `inta` (registered) = EN & ((RXIE & RXF) | (TXIE & TXE)).
- Simultaneous events:
  - RXDATA read in the same cycle as a byte completes: the new byte loads, RXF stays 1, OVR does not set.
  - TXDATA write in the same cycle as a shifter load: the load uses the pre-write state; the written byte is kept and TXF=1 afterwards.
  - W1C of OVR/UNF in the same cycle as a set event: the set wins.
- Reset values:
  - `rt_ack`, `rt_dat_r`, `inta`, `miso`, `miso_oe` = 0;
  - all registers 0, hence TXE=1;
  - synchronizers reset to idle (`csn`=1, `sck`=0).

## Timing
- Wishbone:
  - `rt_ack` asserts 1 cycle after `rt_cyc & rt_stb` and stays high for exactly 1 cycle; no back-to-back ack on the same strobe.
  - Read data is valid with ack.
  - Register side effects (pop, set, W1C) occur on the ack cycle.
- Pin-to-action latency is SYNC_STAGES+1 clocks (3 at default).
- Requirements on the initiator:
  - `clock` ≥ 8× `sck`;
  - first `sck` rise ≥ 4 clocks after `csn` falls;
  - `csn` high time ≥ 4 clocks.
- `miso` updates SYNC_STAGES+1 clocks after an `sck` pin fall. The first bit is valid SYNC_STAGES+1 clocks after `csn` falls.
- RXF rises SYNC_STAGES+2 clocks after the 8th `sck` pin rise. `inta` follows RXF 1 clock later.

## Structure
- Package `fwspi_target_pkg`:
  - register offsets: `REG_RXDATA`, `REG_TXDATA`, `REG_STATUS`, `REG_CTRL`;
  - STATUS/CTRL bit indices;
  - `IDLE_BYTE` = 8'hFF.
- Sub-module `fwspi_target_shifter`:
  - contains: synchronizers, edge detection, bit counter, RX/TX shift registers;
  - outputs to the top: `rx_valid` and `rx_byte`, `tx_load` requests, `busy`.
- Top level contains the Wishbone decode, holding registers, flags and `inta`.

## Test plan
- EN=1, TXDATA=0xA5, initiator sends 0x3C → initiator receives 0xA5; RXDATA=0x3C, RXF=1, TXE=1; `inta`=1 with RXIE=1.
- Two-byte frame, TXDATA=0x11 written before the frame and 0x22 written after the first byte, initiator sends 0x01 then 0x02 with RXDATA read between → returns 0x11, 0x22; reads give 0x01, 0x02; OVR=0, UNF=0.
- Two bytes received without reading RXDATA → RXDATA=first byte, OVR=1; writing STATUS with 0x04 clears OVR.
- Frame started with TXE=1 → `miso` shifts out 0xFF and UNF=1.
- `csn` raised after 5 bits, then a full byte 0x5A is sent → only 0x5A is captured, RXF=1.
- `reset` asserted mid-frame → all outputs 0 immediately; after release, STATUS reads 0x02.
